sd_card_fetch: RTL and testbench

- Sits between the W65C832 memory bus and the sd_card_sdhc 512-byte page buffer, downstream of the CPU request and upstream of the pager.
- Converts one 1–4 byte little-endian read request into a sequence of single-byte pager accesses.
- Handles the pager's busy/page-miss timing, page crossings inside a multi-byte read, and a stuck-card timeout.
- Returns one assembled 32-bit word with a one-cycle done pulse.

---
 rtl/sd_card_fetch.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sd_card_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_fetch.sv
// sd_card_fetch
//   Turns one 1-4 byte little-endian read from the W65C832 bus into a series
//   of single-byte accesses to the sd_card_sdhc 512-byte page buffer (pager).
//   It follows the pager's busy/page-miss handshake and gives up on a byte
//   whose busy never clears. The assembled word comes back with a one-cycle
//   done pulse.
//
// Optional build macro: SD_FETCH_LAST_EN
//   When defined, the last error-free result is remembered. An identical
//   request (same address and width) is then answered from that copy without
//   touching the pager. When undefined, every request walks the full FSM.
//
// Ports
//   clk         system clock
//   reset       asynchronous reset, active low
//   req         read request, sampled only while idle
//   address     byte address of the lowest byte
//   width       number of bytes minus one (0..3)
//   data_out    assembled word; byte i in [8i+7:8i], unused bytes zero
//   done        one-cycle pulse; data_out/error valid
//   busy        high from acceptance until the done cycle
//   error       set with done when a byte timed out
//   sd_address  byte address presented to the pager
//   sd_enable   pager enable; sticky once the first request is accepted
//   sd_data     pager read data
//   sd_busy     pager busy
module sd_card_fetch #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [23:0] address,
  input  logic [1:0]  width,
  output logic [31:0] data_out,
  output logic        done,
  output logic        busy,
  output logic        error,
  output logic [23:0] sd_address,
  output logic        sd_enable,
  input  logic [7:0]  sd_data,
  input  logic        sd_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_HIT    = 3'd5   // only reachable with SD_FETCH_LAST_EN
  } state_t;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] ptr_q, ptr_d;
  logic [1:0]  width_q, width_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  settle_q, settle_d;
  logic [23:0] tmo_q, tmo_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic [23:0] sd_addr_q, sd_addr_d;
  logic        sd_en_q, sd_en_d;

`ifdef SD_FETCH_LAST_EN
  logic [23:0] start_q, start_d;
  logic        last_valid_q, last_valid_d;
  logic [23:0] last_addr_q, last_addr_d;
  logic [1:0]  last_width_q, last_width_d;
  logic [31:0] last_data_q, last_data_d;
  logic        last_match_s;

  // Identical request to the last good one can be served from the copy.
  always_comb begin
    last_match_s = last_valid_q && (last_addr_q == address) && (last_width_q == width);
  end
`endif

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    width_d   = width_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    error_d   = error_q;
    sd_addr_d = sd_addr_q;
    sd_en_d   = sd_en_q;
`ifdef SD_FETCH_LAST_EN
    start_d      = start_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    last_width_d = last_width_q;
    last_data_d  = last_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          ptr_d   = address;
          width_d = width;
          idx_d   = 2'd0;
          data_d  = 32'd0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          // The pager only progresses while enabled, so never drop it again.
          sd_en_d = 1'b1;
`ifdef SD_FETCH_LAST_EN
          start_d = address;
          if (last_match_s) begin
            data_d  = last_data_q;
            state_d = S_HIT;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        sd_addr_d = ptr_q;
        settle_d  = 8'd0;
        state_d   = S_SETTLE;
      end

      // Pager busy/data are registered: a busy=0 left over from the previous
      // hit must not be mistaken for the answer to the new address.
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          tmo_d   = 24'd0;
          state_d = S_WAIT;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end

      S_WAIT: begin
        if (!sd_busy) begin
          case (idx_q)
            2'd0:    data_d[7:0]   = sd_data;
            2'd1:    data_d[15:8]  = sd_data;
            2'd2:    data_d[23:16] = sd_data;
            default: data_d[31:24] = sd_data;
          endcase
          if (idx_q == width_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Page crossings need no special case: the pager just misses.
            idx_d   = idx_q + 2'd1;
            ptr_d   = ptr_q + 24'd1;
            state_d = S_ISSUE;
          end
        end else if (tmo_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SD_FETCH_LAST_EN
          last_valid_d = 1'b0;
`endif
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

`ifdef SD_FETCH_LAST_EN
      S_HIT: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
`ifdef SD_FETCH_LAST_EN
        if (!error_q) begin
          last_valid_d = 1'b1;
          last_addr_d  = start_q;
          last_width_d = width_q;
          last_data_d  = data_q;
        end else begin
          last_valid_d = 1'b0;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any request without a done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 24'd0;
      width_q   <= 2'd0;
      idx_q     <= 2'd0;
      settle_q  <= 8'd0;
      tmo_q     <= 24'd0;
      data_q    <= 32'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      sd_addr_q <= 24'd0;
      sd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      width_q   <= width_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      sd_addr_q <= sd_addr_d;
      sd_en_q   <= sd_en_d;
    end
  end

`ifdef SD_FETCH_LAST_EN
  // Last-result copy used by the repeat-request shortcut.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q      <= 24'd0;
      last_valid_q <= 1'b0;
      last_addr_q  <= 24'd0;
      last_width_q <= 2'd0;
      last_data_q  <= 32'd0;
    end else begin
      start_q      <= start_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      last_width_q <= last_width_d;
      last_data_q  <= last_data_d;
    end
  end
`endif

  assign data_out   = data_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign sd_address = sd_addr_q;
  assign sd_enable  = sd_en_q;

endmodule

// File: tb/tb_sd_card_fetch.sv
// Self-checking bench for sd_card_fetch with a behavioural page-buffer model.
// Expected results are queued when a request is driven and compared when the
// DUT pulses done.
module tb_sd_card_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [23:0] address;
  logic [1:0]  width;
  logic [31:0] data_out;
  logic        done;
  logic        busy;
  logic        error;
  logic [23:0] sd_address;
  logic        sd_enable;
  logic [7:0]  sd_data;
  logic        sd_busy;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] addr_obs[$];
  logic [23:0] prev_addr = 24'd0;

  always #5 clk = ~clk;

  sd_card_fetch #(
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(24'd50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .address   (address),
    .width     (width),
    .data_out  (data_out),
    .done      (done),
    .busy      (busy),
    .error     (error),
    .sd_address(sd_address),
    .sd_enable (sd_enable),
    .sd_data   (sd_data),
    .sd_busy   (sd_busy)
  );

  // Page-buffer contents: distinct bytes, 0x11,0x22,.. at 0x10..
  function automatic logic [7:0] pat(input logic [23:0] a);
    logic [3:0] n;
    n = a[3:0] + 4'd1;
    return {n, n} ^ a[16:9] ^ {a[23:17], 1'b0};
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a, input logic [1:0] w);
    logic [31:0] r;
    logic [23:0] b;
    r = 32'd0;
    for (int i = 0; i <= int'(w); i++) begin
      b = a + 24'(i);
      r[8*i +: 8] = pat(b);
    end
    return r;
  endfunction

  // Pager model: registered busy/data, fixed miss latency, optional stuck busy.
  logic        pg_busy = 1'b1;
  logic [7:0]  pg_data = 8'd0;
  logic [14:0] pg_page = 15'd0;
  logic [14:0] ld_page = 15'd0;
  int          ld_cnt  = 0;
  int          miss_lat = 40;
  logic        stuck   = 1'b0;

  always @(posedge clk) begin
    if (!sd_enable) begin
      pg_busy <= 1'b1;
    end else if (stuck) begin
      pg_busy <= 1'b1;
    end else if (ld_cnt != 0) begin
      ld_cnt  <= ld_cnt - 1;
      pg_busy <= 1'b1;
      if (ld_cnt == 1) pg_page <= ld_page;
    end else if (sd_address[23:9] != pg_page) begin
      ld_cnt  <= miss_lat;
      ld_page <= sd_address[23:9];
      pg_busy <= 1'b1;
    end else begin
      pg_busy <= 1'b0;
      pg_data <= pat(sd_address);
    end
  end

  assign sd_busy = pg_busy;
  assign sd_data = pg_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      done_cnt++;
      check("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("data_out", data_out, mon_e.data);
        check("error", 32'(error), 32'(mon_e.err));
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Record the pager address sequence.
  always @(negedge clk) begin
    if (sd_address !== prev_addr) begin
      addr_obs.push_back(sd_address);
      prev_addr = sd_address;
    end
  end

  task automatic issue(input logic [23:0] a, input logic [1:0] w, input bit push,
                       input logic [31:0] expd, input logic experr);
    @(negedge clk);
    address = a;
    width   = w;
    req     = 1'b1;
    if (push) exp_q.push_back('{data: expd, err: experr});
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Counts posedges from the acceptance edge (=1) until done is seen.
  task automatic wait_done(input int max_cyc, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < max_cyc) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_within_budget", 32'(done), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          dc;
    logic [23:0] ea;
    logic [23:0] oa;

    reset   = 1'b0;
    req     = 1'b0;
    address = 24'd0;
    width   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_sd_address", 32'(sd_address), 32'd0);
    check("rst_sd_enable", 32'(sd_enable), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Four-byte all-hit read on page 0.
    issue(24'h000010, 2'd3, 1'b1, 32'h44332211, 1'b0);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("sd_enable_after_accept", 32'(sd_enable), 32'd1);
    wait_done(100, lat);
    check("latency_hit4", lat, 32'd17);

    // Page crossing with a 40-cycle miss on page 1.
    addr_obs.delete();
    dc = done_cnt;
    issue(24'h0001FE, 2'd3, 1'b1, exp_word(24'h0001FE, 2'd3), 1'b0);
    wait_done(300, lat);
    repeat (3) @(negedge clk);
    check("cross_done_once", done_cnt - dc, 32'd1);
    check("cross_addr_count", addr_obs.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ea = 24'h0001FE + 24'(i);
      oa = (i < addr_obs.size()) ? addr_obs[i] : 24'hxxxxxx;
      check("cross_addr_seq", 32'(oa), 32'(ea));
    end

    // Top-of-memory wrap.
    issue(24'hFFFFFF, 2'd0, 1'b1, exp_word(24'hFFFFFF, 2'd0), 1'b0);
    wait_done(300, lat);
    issue(24'hFFFFFF, 2'd1, 1'b1, exp_word(24'hFFFFFF, 2'd1), 1'b0);
    wait_done(300, lat);
    check("wrap_upper_zero", 32'(data_out[31:16]), 32'd0);
    check("wrap_byte1", 32'(data_out[15:8]), 32'(pat(24'h000000)));

    // Stuck busy after the first byte: timeout with only lane 0 kept.
    issue(24'h000020, 2'd3, 1'b1, 32'(pat(24'h000020)), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    stuck = 1'b1;
    wait_done(300, lat);
    stuck = 1'b0;
    issue(24'h000020, 2'd0, 1'b1, 32'(pat(24'h000020)), 1'b0);
    check("error_cleared_on_accept", 32'(error), 32'd0);
    wait_done(100, lat);

    // Asynchronous reset during WAIT: outputs clear, no done for the request.
    dc = done_cnt;
    issue(24'h000030, 2'd3, 1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("arst_data_out", data_out, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sd_address", 32'(sd_address), 32'd0);
    check("arst_sd_enable", 32'(sd_enable), 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_done", done_cnt - dc, 32'd0);
    issue(24'h000040, 2'd1, 1'b1, exp_word(24'h000040, 2'd1), 1'b0);
    check("sd_enable_reasserted", 32'(sd_enable), 32'd1);
    wait_done(100, lat);
    check("latency_hit2", lat, 32'd9);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
